dft_input_reorder: RTL and testbench

DFT_INPUT_REORDER -- requirements
Module: dft_input_reorder

---
 rtl/dft_input_reorder_if.sv | 24 ++
 rtl/dft_input_reorder.sv | 150 +++++++++++++++
 tb/tb_dft_input_reorder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dft_input_reorder_if.sv
// Handshake bundle for dft_input_reorder: natural-order samples in, bit-reversed pairs out.
interface dft_input_reorder_if #(
  parameter int unsigned WORD_SZ = 8
);
  logic [WORD_SZ-1:0] i_sample;
  logic               i_valid;
  logic               o_ready;
  logic [WORD_SZ-1:0] out1;
  logic [WORD_SZ-1:0] out2;
  logic               o_valid;
  logic               i_ready;
  logic               o_frame_start;
  logic               o_frame_end;

  modport master (
    output i_sample, i_valid, i_ready,
    input  o_ready, out1, out2, o_valid, o_frame_start, o_frame_end
  );

  modport slave (
    input  i_sample, i_valid, i_ready,
    output o_ready, out1, out2, o_valid, o_frame_start, o_frame_end
  );
endinterface

// File: rtl/dft_input_reorder.sv
// Ping-pong frame buffer that replays each DFT frame as bit-reversed butterfly operand pairs.
module dft_input_reorder #(
  parameter int unsigned WORD_SZ  = 8,
  parameter int unsigned N_POINTS = 8
) (
  input logic                i_CLK,
  input logic                i_RESET,
  dft_input_reorder_if.slave bus
);
  localparam int unsigned      IdxW     = $clog2(N_POINTS);
  localparam int unsigned      PairW    = IdxW - 1;
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(N_POINTS - 1);
  localparam logic [PairW-1:0] LastPair = PairW'(N_POINTS / 2 - 1);

  typedef enum logic {R_IDLE, R_STREAM} rd_state_e;

  function automatic logic [IdxW-1:0] bitrev(input logic [IdxW-1:0] idx);
    logic [IdxW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(IdxW); i++) r[i] = idx[int'(IdxW) - 1 - i];
    return r;
  endfunction

  logic [WORD_SZ-1:0] mem_q [2][N_POINTS];
  logic [1:0]         full_q, full_d, full_seen_q;
  logic               wr_bank_q;
  logic [IdxW-1:0]    wr_idx_q;
  logic               rd_bank_q, rd_bank_d;
  rd_state_e          state_q, state_d;
  logic [PairW-1:0]   pair_q, pair_d;
  logic [WORD_SZ-1:0] out1_q, out1_d, out2_q, out2_d;
  logic               valid_q, valid_d, start_q, start_d, end_q, end_d;
  logic               accept, wr_last, other_bank;
  logic               load, load_bank, release_bank;
  logic [PairW-1:0]   load_pair;

  assign bus.o_ready       = ~full_q[wr_bank_q];
  assign bus.out1          = out1_q;
  assign bus.out2          = out2_q;
  assign bus.o_valid       = valid_q;
  assign bus.o_frame_start = start_q;
  assign bus.o_frame_end   = end_q;

  assign accept     = bus.i_valid & ~full_q[wr_bank_q];
  assign wr_last    = (wr_idx_q == LastIdx);
  assign other_bank = ~rd_bank_q;

  // Sample storage carries no reset; stale contents are never read without a full flag.
  always_ff @(posedge i_CLK) begin
    if (accept) mem_q[wr_bank_q][wr_idx_q] <= bus.i_sample;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      wr_bank_q <= 1'b0;
      wr_idx_q  <= '0;
    end else if (accept) begin
      wr_idx_q <= wr_idx_q + IdxW'(1);
      if (wr_last) wr_bank_q <= ~wr_bank_q;
    end
  end

  // Fill and release always target different banks, so both updates apply.
  always_comb begin
    full_d = full_q;
    if (accept && wr_last) full_d[wr_bank_q] = 1'b1;
    if (release_bank)      full_d[rd_bank_q] = 1'b0;
  end

  always_comb begin
    state_d      = state_q;
    rd_bank_d    = rd_bank_q;
    pair_d       = pair_q;
    out1_d       = out1_q;
    out2_d       = out2_q;
    valid_d      = valid_q;
    start_d      = start_q;
    end_d        = end_q;
    load         = 1'b0;
    load_bank    = rd_bank_q;
    load_pair    = '0;
    release_bank = 1'b0;

    unique case (state_q)
      // A fresh frame is picked up only once its full flag has been seen for an edge.
      R_IDLE: begin
        if (full_q[rd_bank_q] && full_seen_q[rd_bank_q] && (!valid_q || bus.i_ready)) begin
          load    = 1'b1;
          state_d = R_STREAM;
        end
      end
      R_STREAM: begin
        if (valid_q && bus.i_ready) begin
          if (pair_q == LastPair) begin
            release_bank = 1'b1;
            rd_bank_d    = other_bank;
            if (full_q[other_bank]) begin
              load      = 1'b1;
              load_bank = other_bank;
            end else begin
              state_d = R_IDLE;
              valid_d = 1'b0;
              start_d = 1'b0;
              end_d   = 1'b0;
            end
          end else begin
            load      = 1'b1;
            load_pair = pair_q + PairW'(1);
          end
        end
      end
      default: state_d = R_IDLE;
    endcase

    if (load) begin
      out1_d  = mem_q[load_bank][bitrev({load_pair, 1'b0})];
      out2_d  = mem_q[load_bank][bitrev({load_pair, 1'b1})];
      valid_d = 1'b1;
      start_d = (load_pair == '0);
      end_d   = (load_pair == LastPair);
      pair_d  = load_pair;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_q     <= R_IDLE;
      full_q      <= '0;
      full_seen_q <= '0;
      rd_bank_q   <= 1'b0;
      pair_q      <= '0;
      out1_q      <= '0;
      out2_q      <= '0;
      valid_q     <= 1'b0;
      start_q     <= 1'b0;
      end_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      full_seen_q <= full_q;
      rd_bank_q   <= rd_bank_d;
      pair_q      <= pair_d;
      out1_q      <= out1_d;
      out2_q      <= out2_d;
      valid_q     <= valid_d;
      start_q     <= start_d;
      end_q       <= end_d;
    end
  end
endmodule

// File: tb/tb_dft_input_reorder.sv
// Directed and randomized checks of dft_input_reorder against a frame-level bit-reversal model.
module tb_dft_input_reorder;
  logic clk;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   pairs_seen  = 0;

  logic [17:0] exp_q[$];
  logic [7:0]  frame_buf[$];

  dft_input_reorder_if #(.WORD_SZ(8)) bus ();

  dft_input_reorder #(
    .WORD_SZ (8),
    .N_POINTS(8)
  ) dut (
    .i_CLK  (clk),
    .i_RESET(rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rev3(input int x);
    return ((x & 1) << 2) | (x & 2) | ((x >> 2) & 1);
  endfunction

  // Reference: every presented pair must be the head of the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      frame_buf.delete();
    end else begin
      if (bus.o_valid === 1'b1) begin
        vectors++;
        assert (exp_q.size() != 0) else begin
          miscompares++;
          $error("FAIL pair_unexpected observed %h_%h expected none", bus.out1, bus.out2);
        end
        if (exp_q.size() != 0) begin
          vectors++;
          assert ({bus.out1, bus.out2, bus.o_frame_start, bus.o_frame_end} === exp_q[0]) else begin
            miscompares++;
            $error("FAIL pair_data observed %h expected %h",
                   {bus.out1, bus.out2, bus.o_frame_start, bus.o_frame_end}, exp_q[0]);
          end
          if (bus.i_ready) begin
            void'(exp_q.pop_front());
            pairs_seen++;
          end
        end
      end
      if (bus.i_valid && bus.o_ready) begin
        frame_buf.push_back(bus.i_sample);
        if (frame_buf.size() == 8) begin
          for (int k = 0; k < 4; k++)
            exp_q.push_back({frame_buf[rev3(2 * k)], frame_buf[rev3(2 * k + 1)], k == 0, k == 3});
          frame_buf.delete();
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pair(input string tag, input logic [7:0] e1, input logic [7:0] e2);
    chk({tag, "_valid"}, 32'(bus.o_valid), 1);
    chk({tag, "_out1"}, 32'(bus.out1), 32'(e1));
    chk({tag, "_out2"}, 32'(bus.out2), 32'(e2));
  endtask

  task automatic send(input logic [7:0] s);
    int n;
    n = 0;
    bus.i_sample = s;
    bus.i_valid  = 1'b1;
    @(negedge clk);
    while (!bus.o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    assert (n < 200) else begin
      miscompares++;
      $error("FAIL send_timeout observed %0d cycles expected <200", n);
    end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.i_valid  = 1'b0;
    bus.i_ready  = 1'b1;
    bus.i_sample = '0;
    step();
    step();
    chk("rst_o_valid", 32'(bus.o_valid), 0);
    chk("rst_out1", 32'(bus.out1), 0);
    chk("rst_out2", 32'(bus.out2), 0);
    chk("rst_start", 32'(bus.o_frame_start), 0);
    chk("rst_end", 32'(bus.o_frame_end), 0);
    chk("rst_o_ready", 32'(bus.o_ready), 1);
    rst = 1'b0;

    // Single frame, free-flowing output, latency of two edges
    for (int i = 0; i < 8; i++) send(8'(8'h10 + i));
    chk("lat_e0", 32'(bus.o_valid), 0);
    step();
    chk("lat_e1", 32'(bus.o_valid), 0);
    step();
    chk_pair("p0", 8'h10, 8'h14);
    chk("p0_start", 32'(bus.o_frame_start), 1);
    chk("p0_end", 32'(bus.o_frame_end), 0);
    step();
    chk_pair("p1", 8'h12, 8'h16);
    chk("p1_start", 32'(bus.o_frame_start), 0);
    step();
    chk_pair("p2", 8'h11, 8'h15);
    step();
    chk_pair("p3", 8'h13, 8'h17);
    chk("p3_end", 32'(bus.o_frame_end), 1);
    step();
    chk("after_frame_valid", 32'(bus.o_valid), 0);

    // Both banks filled under back-pressure
    bus.i_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(8'(8'h10 + i));
    chk("full_o_ready", 32'(bus.o_ready), 0);
    bus.i_valid  = 1'b1;
    bus.i_sample = 8'h55;
    repeat (5) step();
    chk("held_o_ready", 32'(bus.o_ready), 0);
    chk_pair("held", 8'h10, 8'h14);
    chk("held_start", 32'(bus.o_frame_start), 1);
    bus.i_valid = 1'b0;

    // Release: eight pairs without a bubble, bank frees after the fourth
    bus.i_ready = 1'b1;
    for (int p = 0; p < 8; p++) begin
      step();
      chk("stream_valid", 32'(bus.o_valid), (p < 7) ? 1 : 0);
      if (p == 2) chk("ready_before_release", 32'(bus.o_ready), 0);
      if (p == 3) begin
        chk("ready_after_release", 32'(bus.o_ready), 1);
        chk("second_frame_start", 32'(bus.o_frame_start), 1);
        chk_pair("second_p0", 8'h18, 8'h1c);
      end
    end
    chk("stall_drain_empty", 32'(exp_q.size()), 0);

    // Random valid gaps and ready toggling
    for (int c = 0; c < 500; c++) begin
      bus.i_ready  = ($urandom_range(0, 3) != 0);
      bus.i_valid  = ($urandom_range(0, 2) != 0);
      bus.i_sample = 8'($urandom);
      step();
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    repeat (40) step();
    chk("random_drain_empty", 32'(exp_q.size()), 0);

    // Reset mid-frame discards the partial frame
    for (int i = 0; i < 5; i++) send(8'(8'h40 + i));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_o_ready", 32'(bus.o_ready), 1);
    chk("midrst_o_valid", 32'(bus.o_valid), 0);
    pairs_seen = 0;
    for (int i = 0; i < 8; i++) send(8'(8'h20 + i));
    step();
    step();
    chk_pair("midrst_p0", 8'h20, 8'h24);
    repeat (10) step();
    chk("midrst_pair_count", 32'(pairs_seen), 4);
    chk("midrst_empty", 32'(exp_q.size()), 0);

    // Reset while a pair is stalled at the output
    bus.i_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'(8'h30 + i));
    step();
    step();
    chk_pair("stalled", 8'h30, 8'h34);
    rst = 1'b1;
    step();
    chk("strst_o_valid", 32'(bus.o_valid), 0);
    chk("strst_out1", 32'(bus.out1), 0);
    chk("strst_out2", 32'(bus.out2), 0);
    chk("strst_o_ready", 32'(bus.o_ready), 1);
    chk("strst_start", 32'(bus.o_frame_start), 0);
    rst = 1'b0;
    bus.i_ready = 1'b1;
    repeat (12) step();
    chk("strst_idle", 32'(bus.o_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
